// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with word FIFO, optional parity and configurable stop length
module uart_tx_fifo #(
    parameter int DBIT       = 8,
    parameter int PARITY     = 0,
    parameter int OS         = 16,
    parameter int SB_TICK    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_tick,
    input  logic                          tx_valid,
    input  logic [DBIT-1:0]               tx_data,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_done_tick,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_OS_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] S_SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [DBIT-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    logic [DBIT-1:0] head;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    assign tx_ready     = (count_q != CNT_FULL);
    assign push         = tx_valid & tx_ready;
    assign head         = mem_q[rd_ptr_q];
    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign fifo_count   = count_q;
    assign busy         = (state_q != ST_IDLE) | (count_q != '0);

    // Storage needs no reset: a word is only read once count_q says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Pops are only issued from the registered count, so a word written this cycle waits one clk.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    par_d   = (PARITY == 2) ? ~^head : ^head;
                    s_d     = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_q == S_OS_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                tx_d = shreg_q[0];
                if (s_tick) begin
                    if (s_q == S_OS_LAST) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = par_q;
                if (s_tick) begin
                    if (s_q == S_OS_LAST) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_q == S_SB_LAST) begin
                        done_d = 1'b1;
                        s_d    = '0;
                        // Chain straight into the next start bit when more words are waiting.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shreg_d = head;
                            par_d   = (PARITY == 2) ? ~^head : ^head;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int NCYC = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tick  = 1'b1;
    logic tick_d = 1'b0;
    int   tdiv  = 0;
    int   cyc   = 0;
    int   checks = 0;
    int   failures = 0;

    logic       va = 1'b0, vb = 1'b0, vc = 1'b0, vd = 1'b0;
    logic [7:0] da = '0, db = '0, dc = '0;
    logic [6:0] dd = '0;
    logic       ra, rb, rc, rd;
    logic       txa, txb, txc, txd;
    logic       dna, dnb, dnc, dnd;
    logic       ba, bb, bc, bd;
    logic [2:0] ca, cb, cc, cd;

    uart_tx_fifo u_a (
        .clk(clk), .reset(reset), .s_tick(tick), .tx_valid(va), .tx_data(da),
        .tx_ready(ra), .tx(txa), .tx_done_tick(dna), .busy(ba), .fifo_count(ca));
    uart_tx_fifo #(.PARITY(1)) u_b (
        .clk(clk), .reset(reset), .s_tick(tick), .tx_valid(vb), .tx_data(db),
        .tx_ready(rb), .tx(txb), .tx_done_tick(dnb), .busy(bb), .fifo_count(cb));
    uart_tx_fifo #(.PARITY(2)) u_c (
        .clk(clk), .reset(reset), .s_tick(tick), .tx_valid(vc), .tx_data(dc),
        .tx_ready(rc), .tx(txc), .tx_done_tick(dnc), .busy(bc), .fifo_count(cc));
    uart_tx_fifo #(.DBIT(7), .SB_TICK(32)) u_d (
        .clk(clk), .reset(reset), .s_tick(tick_d), .tx_valid(vd), .tx_data(dd),
        .tx_ready(rd), .tx(txd), .tx_done_tick(dnd), .busy(bd), .fifo_count(cd));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        tdiv   = (tdiv == 2) ? 0 : tdiv + 1;
        tick_d = (tdiv == 0);
    end

    logic [3:0] wtx [NCYC];
    logic [3:0] wdn [NCYC];
    logic       wbs [NCYC];

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            wtx[cyc] = {txd, txc, txb, txa};
            wdn[cyc] = {dnd, dnc, dnb, dna};
            wbs[cyc] = ba;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic gtx(input int sel, input int i);
        if (i < 0 || i >= NCYC) return 1'bx;
        return wtx[i][sel];
    endfunction

    function automatic logic gdn(input int sel, input int i);
        if (i < 0 || i >= NCYC) return 1'bx;
        return wdn[i][sel];
    endfunction

    function automatic logic gbs(input int i);
        if (i < 0 || i >= NCYC) return 1'bx;
        return wbs[i];
    endfunction

    function automatic int find_fall(input int sel, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            if (gtx(sel, i - 1) === 1'b1 && gtx(sel, i) === 1'b0) return i;
        end
        return -1;
    endfunction

    // seq[j] is the j-th 16-clk symbol on the line, start bit first
    task automatic check_frame(input string tag, input int sel, input int f,
                               input logic [15:0] seq, input int nsym);
        int len, bad, ndone;
        len = nsym * 16;
        bad = 0;
        ndone = 0;
        for (int i = 0; i < len; i++) begin
            if (gtx(sel, f + i) !== seq[i / 16]) bad++;
            if (gdn(sel, f + i) === 1'b1) ndone++;
        end
        check({tag, ".bits"}, bad, 0);
        check({tag, ".ndone"}, ndone, 1);
        check({tag, ".done_pos"}, 32'(gdn(sel, f + len - 1)), 1);
    endtask

    initial begin
        int k, f, f0, bad, i, nt, seen_full, rbad, guard;
        int t[8];
        logic acc;

        // Reset state, then idle with s_tick held high
        repeat (3) @(negedge clk);
        check("rst.tx", txa, 1);
        check("rst.ready", ra, 1);
        check("rst.count", ca, 0);
        check("rst.busy", ba, 0);
        check("rst.done", dna, 0);
        reset = 1'b0;
        wait_cyc(20);
        k = cyc;
        bad = 0;
        for (int x = k - 18; x < k; x++) if (gtx(0, x) !== 1'b1) bad++;
        check("idle.tx_high", bad, 0);

        // 0xA5 default frame; 0x07 with even and odd parity
        k = cyc;
        va = 1'b1; da = 8'hA5;
        vb = 1'b1; db = 8'h07;
        vc = 1'b1; dc = 8'h07;
        @(negedge clk);
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        wait_cyc(190);
        f = find_fall(0, k, k + 10);
        check("t2.latency", f - k, 3);
        check_frame("t2.a5", 0, f, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        f = find_fall(1, k, k + 10);
        check("t3.even.latency", f - k, 3);
        check_frame("t3.even", 1, f, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        f = find_fall(2, k, k + 10);
        check_frame("t3.odd", 2, f, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);

        // Eight words with tx_valid held; FIFO fills and backpressures
        k = cyc;
        i = 0; rbad = 0; seen_full = 0; guard = 0;
        while (i < 8 && guard < 2000) begin
            va = 1'b1;
            da = 8'(i + 1);
            acc = ra;
            if (ra !== (ca != 3'd4)) rbad++;
            if (ca === 3'd4) seen_full = 1;
            @(negedge clk);
            guard++;
            if (acc) i++;
        end
        va = 1'b0;
        check("t4.all_pushed", i, 8);
        check("t4.ready_vs_count", rbad, 0);
        check("t4.reached_full", seen_full, 1);
        guard = 0;
        while (ba !== 1'b0 && guard < 1500) begin
            @(negedge clk);
            guard++;
        end
        check("t4.busy_falls", ba, 0);
        wait_cyc(30);
        f0 = find_fall(0, k, k + 10);
        check("t4.latency", f0 - k, 3);
        for (int j = 0; j < 8; j++) begin
            check_frame($sformatf("t4.w%0d", j + 1), 0, f0 + 160 * j,
                        {6'b0, 1'b1, 8'(j + 1), 1'b0}, 10);
        end
        check("t4.busy_before_end", 32'(gbs(f0 + 1278)), 1);
        check("t4.busy_at_end", 32'(gbs(f0 + 1279)), 0);
        check("t4.no_extra_frame", find_fall(0, f0 + 1280, f0 + 1300), -1);

        // Reset in the middle of a data bit with two words queued
        k = cyc;
        va = 1'b1; da = 8'h11;
        @(negedge clk); da = 8'h22;
        @(negedge clk); da = 8'h33;
        @(negedge clk); va = 1'b0;
        wait_cyc(37);
        check("t5.queued", ca, 2);
        check("t5.mid_bit_low", txa, 0);
        reset = 1'b1;
        #1;
        check("t5.rst.tx", txa, 1);
        check("t5.rst.count", ca, 0);
        check("t5.rst.ready", ra, 1);
        check("t5.rst.busy", ba, 0);
        check("t5.rst.done", dna, 0);
        k = cyc;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(30);
        check("t5.no_frame_after", find_fall(0, k, cyc - 1), -1);
        bad = 0;
        for (int x = k; x < cyc; x++) if (gdn(0, x) !== 1'b0) bad++;
        check("t5.no_done", bad, 0);
        k = cyc;
        va = 1'b1; da = 8'h3C;
        @(negedge clk);
        va = 1'b0;
        wait_cyc(175);
        f = find_fall(0, k, k + 10);
        check("t5.post.latency", f - k, 3);
        check_frame("t5.post", 0, f, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);

        // DBIT=7, two stop bits, s_tick every third clk, word 0x55
        k = cyc;
        vd = 1'b1; dd = 7'h55;
        @(negedge clk);
        vd = 1'b0;
        wait_cyc(700);
        f = find_fall(3, k, k + 10);
        check("t6.latency", f - k, 3);
        nt = 0;
        for (int x = f + 1; x <= f + 650; x++) begin
            if (gtx(3, x) !== gtx(3, x - 1)) begin
                if (nt < 8) t[nt] = x;
                nt++;
            end
        end
        check("t6.transitions", nt, 7);
        check("t6.start_len", ((t[0] - f) >= 46 && (t[0] - f) <= 48) ? 1 : 0, 1);
        bad = 0;
        for (int j = 1; j < 7; j++) if (t[j] - t[j - 1] != 48) bad++;
        check("t6.bit_len", bad, 0);
        check("t6.last_bit_high", 32'(gtx(3, t[6])), 1);
        check("t6.done_pos", 32'(gdn(3, t[6] + 143)), 1);
        bad = 0;
        for (int x = f; x <= f + 650; x++) if (gdn(3, x) === 1'b1) bad++;
        check("t6.ndone", bad, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
